// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes I/O read/write cycles that fall inside an
// aligned window of NUM_REGS byte registers at BASE_ADDR and bridges them to a
// simple request/acknowledge register port. Long-wait SYNC is sent until the
// register side acknowledges, and an error SYNC once MAX_WAIT waits expire.
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR = 16'h0C00,
    parameter int          NUM_REGS  = 32,
    parameter int          MAX_WAIT  = 64,
    localparam int         ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic              PciReset,
    input  logic              LpcClock,
    input  logic              LpcFrame,
    input  logic [3:0]        LpcAdIn,
    output logic [3:0]        LpcAdOut,
    output logic              LpcAdOe,
    output logic              RegWr,
    output logic              RegRd,
    output logic [ADDR_W-1:0] RegAddr,
    output logic [7:0]        RegWrData,
    input  logic [7:0]        RegRdData,
    input  logic              RegAck,
    output logic              SyncErr
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [3:0] LAD_START  = 4'b0000;
    localparam logic [3:0] LAD_ABORT  = 4'b1111;
    localparam logic [3:0] LAD_IDLE   = 4'b1111;
    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;
    localparam logic [3:0] SYNC_OK    = 4'b0000;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_HTAR1,
        ST_HTAR2,
        ST_SYNC,
        ST_RDATA,
        ST_TTAR1,
        ST_TTAR2,
        ST_SKIP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          nib_q, nib_d;
    logic [11:0]         addr_q, addr_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [3:0]          lad_out_q, lad_out_d;
    logic                lad_oe_q, lad_oe_d;
    logic                reg_wr_q, reg_wr_d;
    logic                reg_rd_q, reg_rd_d;
    logic                sync_err_q, sync_err_d;

    logic [15:0]         addr_shift;
    logic                addr_hit;
    logic                ack_now;

    // Full address as it stands once the current nibble is shifted in.
    assign addr_shift = {addr_q, LpcAdIn};
    assign addr_hit   = (addr_shift[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
    // An acknowledge only counts while a request is outstanding.
    assign ack_now    = (reg_wr_q | reg_rd_q) & RegAck;

    // Next-state and datapath capture for the LPC cycle decoder.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d    = state_q;
        nib_d      = nib_q;
        addr_d     = addr_q;
        is_write_d = is_write_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        rd_data_d  = rd_data_q;

        if (ack_now) begin
            rd_data_d = RegRdData;
        end

        if (!LpcFrame && LpcAdIn == LAD_START) begin
            state_d = ST_CYCTYPE;
        end else if (!LpcFrame && LpcAdIn == LAD_ABORT) begin
            state_d = ST_IDLE;
        end else if (!LpcFrame && state_q != ST_IDLE) begin
            // Some other start code from the host: not a cycle for us.
            state_d = ST_SKIP;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CYCTYPE: begin
                    nib_d = 2'd0;
                    if (LpcAdIn == CYC_IO_RD) begin
                        is_write_d = 1'b0;
                        state_d    = ST_ADDR;
                    end else if (LpcAdIn == CYC_IO_WR) begin
                        is_write_d = 1'b1;
                        state_d    = ST_ADDR;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
                ST_ADDR: begin
                    addr_d = addr_shift[11:0];
                    nib_d  = nib_q + 2'd1;
                    if (nib_q == 2'd3) begin
                        nib_d = 2'd0;
                        if (addr_hit) begin
                            reg_addr_d = addr_shift[ADDR_W-1:0];
                            state_d    = is_write_q ? ST_WDATA : ST_HTAR1;
                        end else begin
                            state_d = ST_SKIP;
                        end
                    end
                end
                ST_WDATA: begin
                    if (nib_q == 2'd0) begin
                        wr_data_d[3:0] = LpcAdIn;
                        nib_d          = 2'd1;
                    end else begin
                        wr_data_d[7:4] = LpcAdIn;
                        nib_d          = 2'd0;
                        state_d        = ST_HTAR1;
                    end
                end
                ST_HTAR1: state_d = ST_HTAR2;
                ST_HTAR2: state_d = ST_SYNC;
                ST_SYNC: begin
                    // The SYNC code currently on the bus decides where we go.
                    if (lad_out_q == SYNC_ERR) begin
                        state_d = ST_TTAR1;
                    end else if (lad_out_q == SYNC_OK) begin
                        nib_d   = 2'd0;
                        state_d = is_write_q ? ST_TTAR1 : ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (nib_q == 2'd0) begin
                        nib_d = 2'd1;
                    end else begin
                        state_d = ST_TTAR1;
                    end
                end
                ST_TTAR1: state_d = ST_TTAR2;
                ST_TTAR2: state_d = ST_IDLE;
                ST_SKIP:  state_d = ST_SKIP;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        lad_oe_d   = 1'b0;
        lad_out_d  = LAD_IDLE;
        reg_wr_d   = 1'b0;
        reg_rd_d   = 1'b0;
        sync_err_d = 1'b0;
        wait_cnt_d = '0;

        unique case (state_d)
            ST_HTAR2: begin
                reg_wr_d = is_write_d;
                reg_rd_d = !is_write_d;
            end
            ST_SYNC: begin
                lad_oe_d = 1'b1;
                if (ack_now) begin
                    lad_out_d = SYNC_OK;
                end else if (state_q == ST_SYNC && wait_cnt_q >= WAIT_W'(MAX_WAIT)) begin
                    lad_out_d  = SYNC_ERR;
                    sync_err_d = 1'b1;
                    wait_cnt_d = wait_cnt_q;
                end else begin
                    lad_out_d  = SYNC_LWAIT;
                    wait_cnt_d = (state_q == ST_SYNC) ? wait_cnt_q + WAIT_W'(1) : WAIT_W'(1);
                    reg_wr_d   = reg_wr_q;
                    reg_rd_d   = reg_rd_q;
                end
            end
            ST_RDATA: begin
                lad_oe_d  = 1'b1;
                lad_out_d = (nib_d == 2'd0) ? rd_data_q[3:0] : rd_data_q[7:4];
            end
            ST_TTAR1: begin
                lad_oe_d  = 1'b1;
                lad_out_d = LAD_IDLE;
            end
            default: begin
                lad_oe_d  = 1'b0;
                lad_out_d = LAD_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by PCI reset.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q    <= ST_IDLE;
            nib_q      <= 2'd0;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= 8'h00;
            rd_data_q  <= 8'h00;
            wait_cnt_q <= '0;
            lad_out_q  <= LAD_IDLE;
            lad_oe_q   <= 1'b0;
            reg_wr_q   <= 1'b0;
            reg_rd_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            nib_q      <= nib_d;
            addr_q     <= addr_d;
            is_write_q <= is_write_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= rd_data_d;
            wait_cnt_q <= wait_cnt_d;
            lad_out_q  <= lad_out_d;
            lad_oe_q   <= lad_oe_d;
            reg_wr_q   <= reg_wr_d;
            reg_rd_q   <= reg_rd_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign LpcAdOut  = lad_out_q;
    assign LpcAdOe   = lad_oe_q;
    assign RegWr     = reg_wr_q;
    assign RegRd     = reg_rd_q;
    assign RegAddr   = reg_addr_q;
    assign RegWrData = wr_data_q;
    assign SyncErr   = sync_err_q;

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed testbench for lpc_io_target: write, late-ack read, decode misses,
// wait timeout, host abort and mid-cycle reset, with hand-computed expectations.
module tb_lpc_io_target;

    logic       PciReset;
    logic       LpcClock;
    logic       LpcFrame;
    logic [3:0] LpcAdIn;
    logic [3:0] LpcAdOut;
    logic       LpcAdOe;
    logic       RegWr;
    logic       RegRd;
    logic [4:0] RegAddr;
    logic [7:0] RegWrData;
    logic [7:0] RegRdData;
    logic       RegAck;
    logic       SyncErr;

    int n_checks = 0;
    int n_fails  = 0;

    // Activity counters sampled away from the active edge.
    int oe_cycles  = 0;
    int req_cycles = 0;
    int err_pulses = 0;
    int lad_viol   = 0;

    lpc_io_target #(
        .BASE_ADDR(16'h0C00),
        .NUM_REGS (32),
        .MAX_WAIT (4)
    ) dut (
        .PciReset (PciReset),
        .LpcClock (LpcClock),
        .LpcFrame (LpcFrame),
        .LpcAdIn  (LpcAdIn),
        .LpcAdOut (LpcAdOut),
        .LpcAdOe  (LpcAdOe),
        .RegWr    (RegWr),
        .RegRd    (RegRd),
        .RegAddr  (RegAddr),
        .RegWrData(RegWrData),
        .RegRdData(RegRdData),
        .RegAck   (RegAck),
        .SyncErr  (SyncErr)
    );

    initial LpcClock = 1'b0;
    always #15 LpcClock = ~LpcClock;

    always @(negedge LpcClock) begin
        if (LpcAdOe) oe_cycles++;
        if (RegWr || RegRd) req_cycles++;
        if (SyncErr) err_pulses++;
        if (!LpcAdOe && LpcAdOut !== 4'hF) lad_viol++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic oe, input logic [3:0] lad,
                             input logic wr, input logic rd, input logic err);
        check({tag, ".oe"},  16'(LpcAdOe),  16'(oe));
        check({tag, ".lad"}, 16'(LpcAdOut), 16'(lad));
        check({tag, ".wr"},  16'(RegWr),    16'(wr));
        check({tag, ".rd"},  16'(RegRd),    16'(rd));
        check({tag, ".err"}, 16'(SyncErr),  16'(err));
    endtask

    // Drive one LPC clock: inputs change on the falling edge, outputs are
    // observed 1 ns after the following rising edge.
    task automatic tick(input logic f, input logic [3:0] ad);
        @(negedge LpcClock);
        LpcFrame = f;
        LpcAdIn  = ad;
        @(posedge LpcClock);
        #1;
    endtask

    // START, cycle type and four address nibbles (MSB first).
    task automatic send_header(input logic [3:0] cyc, input logic [15:0] a);
        tick(1'b0, 4'h0);
        tick(1'b1, cyc);
        for (int i = 3; i >= 0; i--) tick(1'b1, a[i*4 +: 4]);
    endtask

    task automatic do_write(input string tag, input logic [15:0] a, input logic [3:0] d_lo,
                            input logic [3:0] d_hi, input logic [4:0] exp_idx,
                            input logic [7:0] exp_data, input int late);
        send_header(4'h2, a);
        tick(1'b1, d_lo);
        tick(1'b1, d_hi);
        check_bus({tag, ".htar1"}, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus({tag, ".htar2"}, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
        check({tag, ".addr"}, 16'(RegAddr),   16'(exp_idx));
        check({tag, ".data"}, 16'(RegWrData), 16'(exp_data));
        for (int i = 0; i < late; i++) begin
            tick(1'b1, 4'hF);
            check_bus({tag, ".wait"}, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
            check({tag, ".data_hold"}, 16'(RegWrData), 16'(exp_data));
        end
        RegAck = 1'b1;
        tick(1'b1, 4'hF);
        RegAck = 1'b0;
        check_bus({tag, ".sync"}, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus({tag, ".ttar1"}, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus({tag, ".ttar2"}, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
    endtask

    task automatic do_read(input string tag, input logic [15:0] a, input int late,
                           input logic [7:0] rdata, input logic [4:0] exp_idx,
                           input logic [3:0] exp_lo, input logic [3:0] exp_hi);
        send_header(4'h0, a);
        check_bus({tag, ".htar1"}, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus({tag, ".htar2"}, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        check({tag, ".addr"}, 16'(RegAddr), 16'(exp_idx));
        for (int i = 0; i < late; i++) begin
            tick(1'b1, 4'hF);
            check_bus({tag, ".wait"}, 1'b1, 4'h6, 1'b0, 1'b1, 1'b0);
        end
        RegAck    = 1'b1;
        RegRdData = rdata;
        tick(1'b1, 4'hF);
        RegAck    = 1'b0;
        RegRdData = 8'h00;
        check_bus({tag, ".sync"}, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus({tag, ".rd_lo"}, 1'b1, exp_lo, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus({tag, ".rd_hi"}, 1'b1, exp_hi, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus({tag, ".ttar1"}, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus({tag, ".ttar2"}, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
    endtask

    initial begin
        int oe0, rq0, e0;

        PciReset  = 1'b0;
        LpcFrame  = 1'b1;
        LpcAdIn   = 4'hF;
        RegAck    = 1'b0;
        RegRdData = 8'h00;

        // Reset state.
        repeat (3) @(posedge LpcClock);
        #1;
        check_bus("reset", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        check("reset.addr",  16'(RegAddr),   16'h0000);
        check("reset.wdata", 16'(RegWrData), 16'h0000);
        @(negedge LpcClock);
        PciReset = 1'b1;

        // I/O write 0x0C05 <- 0xA5, ack while in HTAR2.
        do_write("wr", 16'h0C05, 4'h5, 4'hA, 5'h05, 8'hA5, 0);

        // I/O read 0x0C1F, ack after three long waits, data 0x3C.
        do_read("rd", 16'h0C1F, 3, 8'h3C, 5'h1F, 4'hC, 4'h3);

        // Decode misses: foreign address and unsupported cycle type.
        oe0 = oe_cycles;
        rq0 = req_cycles;
        send_header(4'h0, 16'h0D05);
        repeat (6) tick(1'b1, 4'hF);
        RegAck    = 1'b1;
        RegRdData = 8'hEE;
        tick(1'b1, 4'hF);
        RegAck    = 1'b0;
        RegRdData = 8'h00;
        send_header(4'h4, 16'h0C05);
        repeat (6) tick(1'b1, 4'hF);
        check("skip.oe_cycles",  16'(oe_cycles - oe0),  16'd0);
        check("skip.req_cycles", 16'(req_cycles - rq0), 16'd0);
        check("skip.addr_kept",  16'(RegAddr),          16'h001F);

        // Read never acknowledged: four long waits then an error SYNC.
        e0 = err_pulses;
        send_header(4'h0, 16'h0C02);
        check_bus("tmo.htar1", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus("tmo.htar2", 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'hF);
            check_bus("tmo.wait", 1'b1, 4'h6, 1'b0, 1'b1, 1'b0);
        end
        tick(1'b1, 4'hF);
        check_bus("tmo.err", 1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 4'hF);
        check_bus("tmo.ttar1", 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus("tmo.ttar2", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus("tmo.idle", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        check("tmo.err_pulses", 16'(err_pulses - e0), 16'd1);

        // Host abort during SYNC, then a normal write.
        send_header(4'h0, 16'h0C03);
        tick(1'b1, 4'hF);
        tick(1'b1, 4'hF);
        check_bus("abort.sync", 1'b1, 4'h6, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 4'hF);
        check_bus("abort.next", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus("abort.idle", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        do_write("wr2", 16'h0C0A, 4'hA, 4'h5, 5'h0A, 8'h5A, 1);

        // Reset asserted while driving read data.
        send_header(4'h0, 16'h0C04);
        tick(1'b1, 4'hF);
        RegAck    = 1'b1;
        RegRdData = 8'h96;
        tick(1'b1, 4'hF);
        RegAck    = 1'b0;
        RegRdData = 8'h00;
        check_bus("rst.sync", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF);
        check_bus("rst.rdata", 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        #2;
        PciReset = 1'b0;
        #1;
        check_bus("rst.async", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        check("rst.addr",  16'(RegAddr),   16'h0000);
        check("rst.wdata", 16'(RegWrData), 16'h0000);
        tick(1'b1, 4'hF);
        tick(1'b1, 4'hF);
        check_bus("rst.held", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge LpcClock);
        PciReset = 1'b1;
        tick(1'b1, 4'hF);
        check_bus("rst.released", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        do_read("rd2", 16'h0C07, 1, 8'h81, 5'h07, 4'h1, 4'h8);

        check("lad_idle_when_released", 16'(lad_viol), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
